// File: rtl/pc_ctrl_pkg.sv
// Shared types, opcode encodings and jump-target table for the program-counter
// control sequencer.
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Decoded control-flow class of one instruction word.
  typedef enum logic [2:0] {
    CF_NONE = 3'd0,
    CF_JMP  = 3'd1,
    CF_CALL = 3'd2,
    CF_RET  = 3'd3,
    CF_BRZ  = 3'd4
  } cf_e;

  localparam int INSTR_LEN = 9;
  localparam int OP_HI     = 8;
  localparam int OP_LO     = 6;

  localparam logic [2:0] OP_JMP  = 3'b111;
  localparam logic [2:0] OP_CALL = 3'b110;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_BRZ  = 3'b100;
  localparam logic [INSTR_LEN-1:0] RET_INSTR = 9'b101_000000;

  localparam int LUT_DEPTH = 64;
  localparam int LUT_IDX_W = 6;
  localparam int LUT_W     = 10;

  // Entry i is i*16 except for the low entries used by the boot code.
  localparam logic [LUT_W-1:0] JUMP_TABLE [LUT_DEPTH] = '{
    10'd0,   10'd20,  10'd30,  10'd40,  10'd64,  10'd80,  10'd96,  10'd112,
    10'd128, 10'd144, 10'd160, 10'd176, 10'd192, 10'd208, 10'd224, 10'd240,
    10'd256, 10'd272, 10'd288, 10'd304, 10'd320, 10'd336, 10'd352, 10'd368,
    10'd384, 10'd400, 10'd416, 10'd432, 10'd448, 10'd464, 10'd480, 10'd496,
    10'd512, 10'd528, 10'd544, 10'd560, 10'd576, 10'd592, 10'd608, 10'd624,
    10'd640, 10'd656, 10'd672, 10'd688, 10'd704, 10'd720, 10'd736, 10'd752,
    10'd768, 10'd784, 10'd800, 10'd816, 10'd832, 10'd848, 10'd864, 10'd880,
    10'd896, 10'd912, 10'd928, 10'd944, 10'd960, 10'd976, 10'd992, 10'd1008
  };

  // RET must match the full word; other 101 patterns are plain instructions.
  function automatic cf_e decode_cf(input logic [INSTR_LEN-1:0] instr);
    cf_e cf;
    cf = CF_NONE;
    case (instr[OP_HI:OP_LO])
      OP_JMP:  cf = CF_JMP;
      OP_CALL: cf = CF_CALL;
      OP_BRZ:  cf = CF_BRZ;
      OP_RET:  cf = (instr == RET_INSTR) ? CF_RET : CF_NONE;
      default: cf = CF_NONE;
    endcase
    return cf;
  endfunction

endpackage

// File: rtl/pc_ctrl_if.sv
// Bundle between the sequencer and the program counter / instruction memory.
// master is the sequencer side, slave is the PC / environment side.
interface pc_ctrl_if #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
);

  logic               start;
  logic [PC_W-1:0]    pc;
  logic               pc_halt;
  logic [INSTR_W-1:0] instr;
  logic               alu_zero;
  logic               flag_we;

  logic               init;
  logic               jump_en;
  logic               branch_en;
  logic [6:0]         counter;
  logic [PC_W-1:0]    destination;
  logic               done;
  logic               ret_err;
  logic [CNT_W-1:0]   cycles;

  modport master (
    input  start, pc, pc_halt, instr, alu_zero, flag_we,
    output init, jump_en, branch_en, counter, destination, done, ret_err, cycles
  );

  modport slave (
    output start, pc, pc_halt, instr, alu_zero, flag_we,
    input  init, jump_en, branch_en, counter, destination, done, ret_err, cycles
  );

endinterface

// File: rtl/pc_ctrl_jump_lut.sv
// Combinational jump-target ROM: 6-bit instruction field to PC-wide target.
module pc_ctrl_jump_lut
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [LUT_IDX_W-1:0] idx_i,
  output logic [PC_W-1:0]      target_o
);

  assign target_o = PC_W'(JUMP_TABLE[idx_i]);

endmodule

// File: rtl/pc_ctrl.sv
// Control-flow sequencer driving the program counter: run/done sequencing,
// jump/call/return/branch decode, link register, zero flag and cycle counter.
module pc_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int INSTR_W     = 9,
  parameter int INIT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic       CLK,
  input  logic       init_n,
  pc_ctrl_if.master  bus
);

  localparam int ICNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam logic [ICNT_W-1:0] ICNT_LAST = ICNT_W'(INIT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [ICNT_W-1:0]  icnt_q, icnt_d;
  logic [PC_W-1:0]    link_q, link_d;
  logic               link_valid_q, link_valid_d;
  logic               zero_q, zero_d;
  logic               ret_err_q, ret_err_d;
  logic [CNT_W-1:0]   cycles_q, cycles_d;

  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    lut_target;
  cf_e                cf;

  assign instr = bus.instr;
  assign cf    = decode_cf(instr);

  pc_ctrl_jump_lut #(
    .PC_W (PC_W)
  ) u_jump_lut (
    .idx_i    (instr[LUT_IDX_W-1:0]),
    .target_o (lut_target)
  );

  assign bus.counter = '0;
  assign bus.done    = (state_q == DONE);
  assign bus.ret_err = ret_err_q;
  assign bus.cycles  = cycles_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no path through
    // the case statements leaves one unassigned and infers a latch.
    state_d         = state_q;
    icnt_d          = icnt_q;
    link_d          = link_q;
    link_valid_d    = link_valid_q;
    zero_d          = zero_q;
    ret_err_d       = ret_err_q;
    cycles_d        = cycles_q;
    bus.init        = 1'b0;
    bus.jump_en     = 1'b0;
    bus.branch_en   = 1'b0;
    bus.destination = '0;

    case (state_q)
      IDLE, DONE: begin
        bus.init = (state_q == IDLE);
        if (bus.start) begin
          // A new run starts from a clean architectural state.
          state_d      = INIT;
          icnt_d       = '0;
          cycles_d     = '0;
          link_valid_d = 1'b0;
          zero_d       = 1'b0;
          ret_err_d    = 1'b0;
        end
      end

      INIT: begin
        bus.init = 1'b1;
        if (icnt_q == ICNT_LAST) begin
          state_d = RUN;
        end else begin
          icnt_d = icnt_q + 1'b1;
        end
      end

      RUN: begin
        if (cycles_q != '1) begin
          cycles_d = cycles_q + 1'b1;
        end
        if (bus.flag_we) begin
          zero_d = bus.alu_zero;
        end

        // Halt outranks whatever control instruction sits at the halted PC.
        if (bus.pc_halt) begin
          state_d = DONE;
        end else begin
          case (cf)
            CF_JMP: begin
              bus.jump_en     = 1'b1;
              bus.destination = lut_target;
            end
            CF_CALL: begin
              bus.jump_en     = 1'b1;
              bus.destination = lut_target;
              link_d          = bus.pc + PC_W'(1);
              link_valid_d    = 1'b1;
            end
            CF_RET: begin
              if (link_valid_q) begin
                bus.jump_en     = 1'b1;
                bus.destination = link_q;
                link_valid_d    = 1'b0;
              end else begin
                ret_err_d = 1'b1;
              end
            end
            CF_BRZ: begin
              bus.branch_en = zero_q;
            end
            default: begin
            end
          endcase
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge init_n) begin
    if (!init_n) begin
      state_q      <= IDLE;
      icnt_q       <= '0;
      link_q       <= '0;
      link_valid_q <= 1'b0;
      zero_q       <= 1'b0;
      ret_err_q    <= 1'b0;
      cycles_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q      <= state_d;
      icnt_q       <= icnt_d;
      link_q       <= link_d;
      link_valid_q <= link_valid_d;
      zero_q       <= zero_d;
      ret_err_q    <= ret_err_d;
      cycles_q     <= cycles_d;
    end
  end

endmodule
